// File: rtl/move_merge_engine.sv
// rtl/move_merge_engine.sv - line-serial 2048 slide/merge engine with score, changed and win
module move_merge_engine #(
  parameter int N         = 4,
  parameter int W         = 12,
  parameter int SCORE_W   = 16,
  parameter int WIN_VALUE = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3:0]         direction,
  input  logic [W-1:0]       matrix   [0:N-1][0:N-1],
  output logic [W-1:0]       matrix_D [0:N-1][0:N-1],
  output logic               r,
  output logic               busy,
  output logic               changed,
  output logic [SCORE_W-1:0] score,
  output logic               win
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  // Accumulator width wide enough that one line's merges plus the running score never wrap
  localparam int AW = SCORE_W + W + 8;
  localparam logic [AW-1:0] SCORE_MAX = {{(AW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [W-1:0]  WIN_TILE  = W'(WIN_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_DONE} state_t;

  state_t               r_state;
  logic [IW-1:0]        r_i;
  logic [3:0]           r_dir;
  logic [W-1:0]         r_work [0:N-1][0:N-1];
  logic [SCORE_W-1:0]   r_acc;
  logic                 r_chg;

  logic                 w_valid;
  logic [W-1:0]         w_in   [0:N-1];
  logic [W-1:0]         w_cmp  [0:N];
  logic [W-1:0]         w_out  [0:N-1];
  logic [AW-1:0]        w_line_score;
  logic                 w_line_chg;
  logic [W-1:0]         w_next [0:N-1][0:N-1];
  logic [AW-1:0]        w_sum;
  logic [SCORE_W-1:0]   w_score_next;
  logic                 w_win;

  assign w_valid = (r_dir != 4'b0000) && ((r_dir & (r_dir - 4'd1)) == 4'b0000);

  // Gather line r_i so that element 0 sits at the edge the tiles move toward
  always_comb begin
    for (int j = 0; j < N; j++) begin
      if (r_dir == 4'b0001)      w_in[j] = r_work[r_i][N-1-j];
      else if (r_dir == 4'b1000) w_in[j] = r_work[j][r_i];
      else if (r_dir == 4'b0100) w_in[j] = r_work[N-1-j][r_i];
      else                       w_in[j] = r_work[r_i][j];
    end
  end

  // Compact non-zero tiles, then merge equal neighbours once each; invalid direction passes through
  always_comb begin
    int k;
    int m;
    logic skip;
    for (int j = 0; j <= N; j++) w_cmp[j] = '0;
    for (int j = 0; j < N; j++)  w_out[j] = '0;
    w_line_score = '0;
    w_line_chg   = 1'b0;
    k    = 0;
    m    = 0;
    skip = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (w_in[j] != '0) begin
        w_cmp[k] = w_in[j];
        k = k + 1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (w_cmp[j] != '0) begin
        // Tiles with the top bit set would overflow when doubled, so they only slide
        if (w_cmp[j] == w_cmp[j+1] && !w_cmp[j][W-1]) begin
          w_out[m]     = {w_cmp[j][W-2:0], 1'b0};
          w_line_score = w_line_score + AW'({w_cmp[j][W-2:0], 1'b0});
          skip         = 1'b1;
        end else begin
          w_out[m] = w_cmp[j];
        end
        m = m + 1;
      end
    end
    if (!w_valid) begin
      for (int j = 0; j < N; j++) w_out[j] = w_in[j];
      w_line_score = '0;
    end
    for (int j = 0; j < N; j++) w_line_chg = w_line_chg | (w_out[j] != w_in[j]);
  end

  // Scatter the processed line back into a copy of the working board
  always_comb begin
    w_next = r_work;
    for (int j = 0; j < N; j++) begin
      if (r_dir == 4'b0001)      w_next[r_i][N-1-j] = w_out[j];
      else if (r_dir == 4'b1000) w_next[j][r_i]     = w_out[j];
      else if (r_dir == 4'b0100) w_next[N-1-j][r_i] = w_out[j];
      else                       w_next[r_i][j]     = w_out[j];
    end
  end

  // Saturating score update and win detection over the board as it will be after this line
  always_comb begin
    w_sum        = AW'(r_acc) + w_line_score;
    w_score_next = (w_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
    w_win        = 1'b0;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        w_win = w_win | (w_next[a][b] == WIN_TILE);
  end

  // Control FSM: capture in IDLE, one line per cycle in LINE, publish results on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_dir   <= '0;
      r_acc   <= '0;
      r_chg   <= 1'b0;
      r       <= 1'b0;
      busy    <= 1'b0;
      changed <= 1'b0;
      score   <= '0;
      win     <= 1'b0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) begin
          r_work[a][b]   <= '0;
          matrix_D[a][b] <= '0;
        end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_work  <= matrix;
            r_dir   <= direction;
            r_acc   <= '0;
            r_chg   <= 1'b0;
            r_i     <= '0;
            busy    <= 1'b1;
            r_state <= S_LINE;
          end
        end
        S_LINE: begin
          r_work <= w_next;
          r_acc  <= w_score_next;
          r_chg  <= r_chg | w_line_chg;
          if (r_i == IW'(N-1)) begin
            busy     <= 1'b0;
            r        <= 1'b1;
            matrix_D <= w_next;
            score    <= w_score_next;
            changed  <= r_chg | w_line_chg;
            win      <= w_win;
            r_state  <= S_DONE;
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        S_DONE: begin
          if (!enable) begin
            r       <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_merge_engine.sv
// tb/tb_move_merge_engine.sv - directed self-checking bench for move_merge_engine
module tb_move_merge_engine;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  direction;
  logic [11:0] matrix   [0:3][0:3];
  logic [11:0] matrix_D [0:3][0:3];
  logic [11:0] exp_m    [0:3][0:3];
  logic        r;
  logic        busy;
  logic        changed;
  logic [15:0] score;
  logic        win;

  int tests = 0;
  int fails = 0;
  int lat;

  move_merge_engine #(.N(4), .W(12), .SCORE_W(16), .WIN_VALUE(2048)) dut (
    .clk(clk), .rst(rst), .enable(enable), .direction(direction),
    .matrix(matrix), .matrix_D(matrix_D), .r(r), .busy(busy),
    .changed(changed), .score(score), .win(win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] pack(input logic [11:0] m [0:3][0:3]);
    logic [191:0] v;
    v = '0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        v[(a*4+b)*12 +: 12] = m[a][b];
    return v;
  endfunction

  task automatic set_row(input int rr, input logic [11:0] a, b, c, d);
    matrix[rr][0] = a; matrix[rr][1] = b; matrix[rr][2] = c; matrix[rr][3] = d;
  endtask

  task automatic set_exp(input int rr, input logic [11:0] a, b, c, d);
    exp_m[rr][0] = a; exp_m[rr][1] = b; exp_m[rr][2] = c; exp_m[rr][3] = d;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 4; a++) begin
      set_row(a, 0, 0, 0, 0);
      set_exp(a, 0, 0, 0, 0);
    end
  endtask

  task automatic run_move(input logic [3:0] dir, input bit hold, output int latency);
    @(negedge clk);
    direction = dir;
    enable    = 1'b1;
    @(negedge clk);
    direction = ~dir;
    if (!hold) enable = 1'b0;
    latency = 0;
    while (!r && latency < 20) begin
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; direction = 4'b0000;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    tests++; if (pack(matrix_D) !== 192'd0) begin fails++; $error("FAIL reset_matrix_D"); end
    tests++; if (r !== 1'b0) begin fails++; $error("FAIL reset_r"); end
    tests++; if (busy !== 1'b0) begin fails++; $error("FAIL reset_busy"); end
    tests++; if (score !== 16'd0) begin fails++; $error("FAIL reset_score %0h", score); end
    tests++; if ({changed, win} !== 2'b00) begin fails++; $error("FAIL reset_changed_win"); end
    rst = 1'b0;

    clear_all();
    set_row(0, 2, 2, 0, 0); set_row(1, 4, 0, 0, 0); set_row(2, 4, 0, 0, 0); set_row(3, 4, 0, 0, 0);
    set_exp(0, 4, 0, 0, 0); set_exp(1, 4, 0, 0, 0); set_exp(2, 4, 0, 0, 0); set_exp(3, 4, 0, 0, 0);
    run_move(4'b0010, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $error("FAIL left_latency %0d", lat); end
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL left_matrix"); end
    tests++; if (score !== 16'd4) begin fails++; $error("FAIL left_score %0h", score); end
    tests++; if (changed !== 1'b1) begin fails++; $error("FAIL left_changed"); end
    tests++; if (busy !== 1'b0) begin fails++; $error("FAIL left_busy_low_with_r"); end
    @(negedge clk);
    tests++; if (r !== 1'b0) begin fails++; $error("FAIL left_r_one_cycle"); end
    @(negedge clk);
    tests++; if (score !== 16'd4) begin fails++; $error("FAIL left_score_holds_idle %0h", score); end

    set_exp(0, 2, 2, 0, 0); set_exp(1, 8, 0, 0, 0); set_exp(2, 4, 0, 0, 0); set_exp(3, 0, 0, 0, 0);
    run_move(4'b1000, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $error("FAIL up_latency %0d", lat); end
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL up_matrix"); end
    tests++; if (score !== 16'd8) begin fails++; $error("FAIL up_score %0h", score); end
    tests++; if (changed !== 1'b1) begin fails++; $error("FAIL up_changed"); end

    clear_all();
    set_row(0, 2, 2, 2, 2); set_row(1, 2, 2, 4, 0);
    set_exp(0, 0, 0, 4, 4); set_exp(1, 0, 0, 4, 4);
    run_move(4'b0001, 1'b0, lat);
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL right_matrix"); end
    tests++; if (score !== 16'd12) begin fails++; $error("FAIL right_score %0h", score); end
    tests++; if ({changed, win} !== 2'b10) begin fails++; $error("FAIL right_changed_win"); end

    clear_all();
    set_row(0, 2, 2, 0, 0);
    @(negedge clk);
    direction = 4'b0010;
    enable    = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $error("FAIL mid_busy_before_reset"); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({r, busy} !== 2'b00) begin fails++; $error("FAIL rst_mid_r_busy"); end
    tests++; if (pack(matrix_D) !== 192'd0) begin fails++; $error("FAIL rst_mid_matrix_D"); end
    tests++; if (score !== 16'd0) begin fails++; $error("FAIL rst_mid_score %0h", score); end
    @(negedge clk);
    rst = 1'b0;
    set_row(1, 4, 0, 4, 0);
    set_exp(0, 4, 0, 0, 0); set_exp(1, 8, 0, 0, 0);
    run_move(4'b0010, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $error("FAIL post_rst_latency %0d", lat); end
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL post_rst_matrix"); end
    tests++; if (score !== 16'd12) begin fails++; $error("FAIL post_rst_score %0h", score); end

    clear_all();
    set_row(0, 2048, 2048, 0, 0);
    set_exp(0, 2048, 2048, 0, 0);
    run_move(4'b0010, 1'b0, lat);
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL limit_matrix"); end
    tests++; if (changed !== 1'b0) begin fails++; $error("FAIL limit_changed"); end
    tests++; if (score !== 16'd0) begin fails++; $error("FAIL limit_score %0h", score); end
    tests++; if (win !== 1'b1) begin fails++; $error("FAIL limit_win"); end

    clear_all();
    set_row(0, 2, 2, 0, 0); set_row(1, 4, 4, 0, 0); set_row(3, 0, 8, 0, 8);
    set_exp(0, 2, 2, 0, 0); set_exp(1, 4, 4, 0, 0); set_exp(3, 0, 8, 0, 8);
    run_move(4'b0011, 1'b1, lat);
    tests++; if (lat !== 4) begin fails++; $error("FAIL inv_latency %0d", lat); end
    tests++; if (pack(matrix_D) !== pack(exp_m)) begin fails++; $error("FAIL inv_matrix"); end
    tests++; if ({changed, score} !== 17'd0) begin fails++; $error("FAIL inv_changed_score"); end
    tests++; if (win !== 1'b0) begin fails++; $error("FAIL inv_win"); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if ({r, busy} !== 2'b10) begin fails++; $error("FAIL inv_r_held %0d", c); end
    end
    enable = 1'b0;
    @(negedge clk);
    tests++; if (r !== 1'b0) begin fails++; $error("FAIL inv_r_drop"); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $error("FAIL inv_no_retrigger"); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
